mem_port_arbiter: RTL and testbench

- Sequences the single-port, fixed-latency main memory and shares it between two requesters: instruction fetch (I port, read-only) and data access (D port, load/store).
- Replaces the hard-coded memory wait states in the control FSM with a req/ack handshake.
- Sits between the control unit / datapath address mux and the memory.
- Data requests have fixed priority; a starvation guard protects fetch.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter: shares a single-port fixed-latency memory between   |
// | instruction fetch (I) and data load/store (D) via req/ack. Rev 1.0    |
// +----------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LAT     = 2,
  parameter int WRITE_LAT    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int c_max_lat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int c_lat_w   = $clog2(c_max_lat + 1);
  localparam int c_sc_w    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic                owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [c_lat_w-1:0]  lat_cnt_q, lat_cnt_d;
  logic [c_sc_w-1:0]   starve_cnt_q, starve_cnt_d;

  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;

  // D has fixed priority unless fetch has lost STARVE_LIMIT arbitrations in a row
  assign w_starved = (STARVE_LIMIT != 0) && (starve_cnt_q >= c_sc_w'(STARVE_LIMIT));
  assign w_grant_d = d_req && !(i_req && w_starved);
  assign w_grant_i = i_req && !w_grant_d;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    mem_wr_d     = mem_wr_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_d || w_grant_i) begin
          state_d    = ST_ACCESS;
          owner_d    = w_grant_d;
          mem_addr_d = w_grant_d ? d_addr : i_addr;
          mem_wr_d   = w_grant_d && d_we;
          if (w_grant_d) begin
            mem_wdata_d = d_wdata;
          end
          lat_cnt_d = (w_grant_d && d_we) ? c_lat_w'(WRITE_LAT - 1)
                                          : c_lat_w'(READ_LAT - 1);
        end
        if (w_grant_d && i_req) begin
          if (starve_cnt_q < c_sc_w'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + c_sc_w'(1);
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == '0) begin
          if (!mem_wr_q) begin
            rdata_d = mem_rdata;
          end
          mem_wr_d = 1'b0;
          state_d  = ST_DONE;
          i_ack_d  = !owner_q;
          d_ack_d  = owner_q;
        end else begin
          lat_cnt_d = lat_cnt_q - c_lat_w'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      mem_wr_q     <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      mem_wr_q     <= mem_wr_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter: random req/ack traffic against a phase-counting  |
// | transaction model, plus READ_LAT=1/4 latency sweep. Rev 1.0           |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int RL = 2;
  localparam int WL = 1;
  localparam int SL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        i_ack, d_ack, mem_wr, busy, owner;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic        sw_req1 = 1'b0;
  logic        sw_req4 = 1'b0;
  logic [31:0] sw_addr = '0;
  logic [31:0] sw_rd = '0;
  logic        s1_iack, s1_dack, s1_wr, s1_busy, s1_owner;
  logic        s4_iack, s4_dack, s4_wr, s4_busy, s4_owner;
  logic [31:0] s1_rdata, s1_maddr, s1_wdata, s4_rdata, s4_maddr, s4_wdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL), .WRITE_LAT(WL), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.READ_LAT(1), .WRITE_LAT(1), .STARVE_LIMIT(SL)) u_rl1 (
    .clock(clock), .reset(reset),
    .i_req(sw_req1), .i_addr(sw_addr), .i_ack(s1_iack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0), .d_ack(s1_dack),
    .rdata(s1_rdata), .mem_addr(s1_maddr), .mem_wdata(s1_wdata), .mem_wr(s1_wr),
    .mem_rdata(sw_rd), .busy(s1_busy), .owner(s1_owner)
  );

  mem_port_arbiter #(.READ_LAT(4), .WRITE_LAT(1), .STARVE_LIMIT(SL)) u_rl4 (
    .clock(clock), .reset(reset),
    .i_req(sw_req4), .i_addr(sw_addr), .i_ack(s4_iack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0), .d_ack(s4_dack),
    .rdata(s4_rdata), .mem_addr(s4_maddr), .mem_wdata(s4_wdata), .mem_wr(s4_wr),
    .mem_rdata(sw_rd), .busy(s4_busy), .owner(s4_owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_ph counts cycles since the grant edge (0 = idle); ack lands at m_lat+1
  int          m_ph, m_lat, m_starve;
  logic        m_owner, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        i_pend, i_acc, d_pend, d_acc;
  logic        in_acc, in_done, gd, gi, did_mid, stress;
  int          p_i, p_d;
  logic [31:0] hist [0:7];

  task automatic model_reset();
    m_ph = 0; m_lat = RL; m_starve = 0;
    m_owner = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    i_pend = 1'b0; i_acc = 1'b0; d_pend = 1'b0; d_acc = 1'b0;
  endtask

  initial begin
    model_reset();
    did_mid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_acc  = (m_ph >= 1) && (m_ph <= m_lat);
      in_done = (m_ph != 0) && (m_ph == m_lat + 1);
      chk("busy",     32'(busy),  32'(m_ph != 0));
      chk("i_ack",    32'(i_ack), 32'(in_done && !m_owner));
      chk("d_ack",    32'(d_ack), 32'(in_done && m_owner));
      chk("mem_wr",   32'(mem_wr), 32'(in_acc && m_we));
      chk("owner",    32'(owner), 32'(m_owner));
      chk("mem_addr", mem_addr, m_addr);
      chk("rdata",    rdata, m_rdata);
      if (in_acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);

      stress = (cyc >= 1000) && (cyc < 1500);
      p_i = stress ? 100 : ((cyc < 2200) ? 40 : 80);
      p_d = stress ? 100 : ((cyc < 2200) ? 60 : 90);

      reset = 1'b1;
      if (!did_mid && cyc > 20 && m_ph == 1 && !m_we) begin
        reset = 1'b0;
        did_mid = 1'b1;
      end else if (!stress && cyc > 50 && $urandom_range(0, 99) == 0) begin
        reset = 1'b0;
      end
      mem_rdata = $urandom;

      if (in_done && !m_owner) begin
        i_pend = 1'b0; i_acc = 1'b0; i_req = 1'b0;
      end else if (!i_pend) begin
        if ($urandom_range(0, 99) < p_i) begin
          i_pend = 1'b1; i_req = 1'b1; i_addr = $urandom;
        end
      end else if (i_acc && $urandom_range(0, 3) == 0) begin
        i_req = ~i_req; i_addr = $urandom;
      end

      if (in_done && m_owner) begin
        d_pend = 1'b0; d_acc = 1'b0; d_req = 1'b0;
      end else if (!d_pend) begin
        if ($urandom_range(0, 99) < p_d) begin
          d_pend = 1'b1; d_req = 1'b1; d_we = $urandom_range(0, 2) == 0;
          d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (d_acc && $urandom_range(0, 3) == 0) begin
        d_req = ~d_req; d_we = ~d_we; d_addr = $urandom; d_wdata = $urandom;
      end

      if (!reset) begin
        i_req = 1'b0; d_req = 1'b0;
        model_reset();
      end else if (m_ph == 0) begin
        gd = 1'b0; gi = 1'b0;
        if (d_req && i_req) begin
          if (SL != 0 && m_starve >= SL) gi = 1'b1;
          else gd = 1'b1;
        end else if (d_req) begin
          gd = 1'b1;
        end else if (i_req) begin
          gi = 1'b1;
        end
        if (gd || gi) begin
          m_ph    = 1;
          m_owner = gd;
          m_we    = gd && d_we;
          m_addr  = gd ? d_addr : i_addr;
          m_lat   = m_we ? WL : RL;
          if (gd) begin
            m_wdata = d_wdata; d_acc = 1'b1;
          end else begin
            i_acc = 1'b1;
          end
        end
        if (gd && i_req) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        else m_starve = 0;
      end else begin
        if (m_ph == m_lat && !m_we) m_rdata = mem_rdata;
        m_ph = (m_ph == m_lat + 1) ? 0 : m_ph + 1;
      end

      @(posedge clock);
      #1;
    end

    // Latency sweep: both sweep instances see the same fetch in the same IDLE cycle
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    sw_addr = 32'h0000_1234;
    sw_req1 = 1'b1; sw_req4 = 1'b1;
    sw_rd = $urandom; hist[0] = sw_rd;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      chk("sw1_ack",  32'(s1_iack), 32'(k == 2));
      chk("sw4_ack",  32'(s4_iack), 32'(k == 5));
      chk("sw1_busy", 32'(s1_busy), 32'(k <= 2));
      chk("sw4_busy", 32'(s4_busy), 32'(k <= 5));
      chk("sw_misc",  32'({s1_dack, s1_wr, s1_owner, s4_dack, s4_wr, s4_owner}), 32'd0);
      if (k == 1) begin
        chk("sw1_addr", s1_maddr, sw_addr);
        chk("sw4_addr", s4_maddr, sw_addr);
        chk("sw1_wdata", s1_wdata, 32'd0);
        chk("sw4_wdata", s4_wdata, 32'd0);
      end
      if (k == 2) begin
        chk("sw1_rdata", s1_rdata, hist[1]);
        sw_req1 = 1'b0;
      end
      if (k == 5) begin
        chk("sw4_rdata", s4_rdata, hist[4]);
        sw_req4 = 1'b0;
      end
      sw_rd = $urandom;
      hist[k] = sw_rd;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
